rename_alloc_ctrl: RTL and testbench

Physical-register allocation controller for the 4-wide rename stage. It owns the circular free list of physical tags and hands up to four new destination tags per cycle to the RAT write port. It reclaims the superseded tags released at commit. On a pipeline flush it rolls back all speculative allocations in one cycle and sequences the RAT restore.

---
 rtl/rename_alloc_ctrl_if.sv | 40 ++++
 rtl/rename_alloc_ctrl.sv | 90 +++++++++
 tb/tb_rename_alloc_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_alloc_ctrl_if.sv
// rename_alloc_ctrl_if: rename/commit/flush bus between the pipeline and the tag allocator
// Signals:
//   dec_valid, dec_wen[3:0]      rename group request, per-slot destination mask (slot 0 oldest)
//   dec_ready, alloc_fire        group accepted / RAT write enable
//   alloc_tag0..3                new physical tag per slot, 0 where dec_wen is clear
//   cmt_en[3:0], cmt_tag0..3     per-slot commit and superseded tag to free
//   flush, restore_en            discard speculation / RAT restore strobe
//   free_count, err              free-list occupancy and sticky error
// master drives requests (pipeline side), slave is the allocator.
interface rename_alloc_ctrl_if #(
    parameter int PREG_W = 6
);
    logic              dec_valid;
    logic [3:0]        dec_wen;
    logic              dec_ready;
    logic              alloc_fire;
    logic [PREG_W-1:0] alloc_tag0;
    logic [PREG_W-1:0] alloc_tag1;
    logic [PREG_W-1:0] alloc_tag2;
    logic [PREG_W-1:0] alloc_tag3;
    logic [3:0]        cmt_en;
    logic [PREG_W-1:0] cmt_tag0;
    logic [PREG_W-1:0] cmt_tag1;
    logic [PREG_W-1:0] cmt_tag2;
    logic [PREG_W-1:0] cmt_tag3;
    logic              flush;
    logic              restore_en;
    logic [PREG_W:0]   free_count;
    logic              err;
    modport master (
        output dec_valid, dec_wen, cmt_en, cmt_tag0, cmt_tag1, cmt_tag2, cmt_tag3, flush,
        input  dec_ready, alloc_fire, alloc_tag0, alloc_tag1, alloc_tag2, alloc_tag3,
               restore_en, free_count, err
    );
    modport slave (
        input  dec_valid, dec_wen, cmt_en, cmt_tag0, cmt_tag1, cmt_tag2, cmt_tag3, flush,
        output dec_ready, alloc_fire, alloc_tag0, alloc_tag1, alloc_tag2, alloc_tag3,
               restore_en, free_count, err
    );
endinterface

// File: rtl/rename_alloc_ctrl.sv
// rename_alloc_ctrl: circular free list of physical tags for a 4-wide rename stage
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   io (slave)    up to four tags handed out per accepted group, superseded tags
//                 reclaimed at commit, one-cycle rollback and RAT restore on flush,
//                 registered free_count and sticky err
module rename_alloc_ctrl #(
    parameter int PREG_W = 6,
    parameter int NPREG  = 64,
    parameter int NARCH  = 32
) (
    input  logic               clk,
    input  logic               resetn,
    rename_alloc_ctrl_if.slave io
);
    typedef enum logic {RUN, RECOVER} state_t;
    typedef logic [PREG_W:0]   ptr_t;
    typedef logic [PREG_W-1:0] tag_t;
    state_t state_q, state_d;
    ptr_t   spec_head_q, spec_head_d, arch_head_q, arch_head_d, tail_q, tail_d;
    tag_t   mem_q [NPREG];
    tag_t   mem_d [NPREG];
    logic   err_q, err_d;
    tag_t   alloc_tag [4];
    tag_t   cmt_tag [4];
    ptr_t   free_count, n_alloc, n_cmt, spec_alloc, off;
    logic   dec_ready, alloc_fire, ovf;
    assign cmt_tag    = '{io.cmt_tag0, io.cmt_tag1, io.cmt_tag2, io.cmt_tag3};
    assign free_count = tail_q - spec_head_q;
    // gated by resetn so no group is accepted while reset is held
    assign dec_ready  = resetn & (state_q == RUN) & (free_count >= ptr_t'(4)) & ~io.flush;
    assign alloc_fire = io.dec_valid & dec_ready;
    assign n_alloc    = ptr_t'($countones(io.dec_wen));
    assign n_cmt      = ptr_t'($countones(io.cmt_en));
    assign spec_alloc = alloc_fire ? spec_head_q + n_alloc : spec_head_q;
    assign ovf        = (free_count + n_cmt) > ptr_t'(NPREG);
    always_comb begin
        state_d     = io.flush ? RECOVER : RUN;
        arch_head_d = arch_head_q;
        tail_d      = tail_q;
        mem_d       = mem_q;
        err_d       = err_q | ((n_cmt != '0) & ovf);
        off         = '0;
        // slots are compressed: slot k takes the entry after all older requesting slots
        for (int k = 0; k < 4; k++) begin
            alloc_tag[k] = io.dec_wen[k] ? mem_q[tag_t'(spec_head_q + off)] : '0;
            off          = off + ptr_t'(io.dec_wen[k]);
        end
        if ((n_cmt != '0) && !ovf) begin
            off = '0;
            for (int k = 0; k < 4; k++) begin
                if (io.cmt_en[k])
                    mem_d[tag_t'(tail_q + off)] = cmt_tag[k];
                off = off + ptr_t'(io.cmt_en[k]);
            end
            tail_d      = tail_q + n_cmt;
            arch_head_d = arch_head_q + n_cmt;
            // committing more than is speculatively outstanding means arch_head overtook spec_head
            err_d       = err_d | ((spec_alloc - arch_head_q) < n_cmt);
        end
        spec_head_d = io.flush ? arch_head_d : spec_alloc;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= RUN;
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= ptr_t'(NPREG - NARCH);
            err_q       <= 1'b0;
            for (int i = 0; i < NPREG; i++)
                mem_q[i] <= (i < NPREG - NARCH) ? tag_t'(NARCH + i) : '0;
        end else begin
            state_q     <= state_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end
    assign io.dec_ready  = dec_ready;
    assign io.alloc_fire = alloc_fire;
    assign io.alloc_tag0 = alloc_tag[0];
    assign io.alloc_tag1 = alloc_tag[1];
    assign io.alloc_tag2 = alloc_tag[2];
    assign io.alloc_tag3 = alloc_tag[3];
    assign io.restore_en = (state_q == RECOVER);
    assign io.free_count = free_count;
    assign io.err        = err_q;
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb_rename_alloc_ctrl: self-checking bench for the rename tag allocator
module tb_rename_alloc_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    rename_alloc_ctrl_if #(.PREG_W(6)) io ();
    rename_alloc_ctrl #(.PREG_W(6), .NPREG(64), .NARCH(32)) dut (
        .clk(clk), .resetn(resetn), .io(io.slave)
    );
    typedef struct packed {
        logic            v;
        logic [3:0]      wen;
        logic [3:0]      cen;
        logic [3:0][5:0] ct;
        logic            fl;
        logic            rdy;
        logic            fire;
        logic [3:0][5:0] tag;
        logic            re;
        logic [6:0]      fc;
        logic            er;
    } vec_t;
    vec_t tbl [9];
    // reference model: free tags in allocation order, speculative tags oldest first,
    // architecturally mapped tags (used only to pick legal commit tags)
    int fq[$];
    int spq[$];
    int live[$];
    int ret_q[$];
    bit rec, merr;
    logic s_rdy, s_fire, s_re, s_err;
    logic [6:0] s_fc;
    logic [5:0] s_tag [4];
    logic [3:0] cen;
    logic [3:0][5:0] ct;
    int j;
    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic do_reset();
        resetn = 1'b0;
        io.dec_valid = 1'b0;
        io.dec_wen = '0;
        io.cmt_en = '0;
        io.cmt_tag0 = '0;
        io.cmt_tag1 = '0;
        io.cmt_tag2 = '0;
        io.cmt_tag3 = '0;
        io.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset dec_ready", io.dec_ready, 0);
        check("reset alloc_fire", io.alloc_fire, 0);
        check("reset restore_en", io.restore_en, 0);
        check("reset err", io.err, 0);
        check("reset free_count", io.free_count, 32);
        resetn = 1'b1;
        fq.delete();
        spq.delete();
        live.delete();
        for (int i = 0; i < 32; i++) begin
            fq.push_back(32 + i);
            live.push_back(i);
        end
        rec = 1'b0;
        merr = 1'b0;
    endtask
    task automatic cyc(input logic v, input logic [3:0] wen, input logic [3:0] c_en,
                       input logic [3:0][5:0] c_tag, input logic fl);
        int fc0, idx, n;
        bit rdy;
        @(negedge clk);
        io.dec_valid = v;
        io.dec_wen = wen;
        io.cmt_en = c_en;
        io.cmt_tag0 = c_tag[0];
        io.cmt_tag1 = c_tag[1];
        io.cmt_tag2 = c_tag[2];
        io.cmt_tag3 = c_tag[3];
        io.flush = fl;
        #1;
        s_rdy = io.dec_ready;
        s_fire = io.alloc_fire;
        s_re = io.restore_en;
        s_err = io.err;
        s_fc = io.free_count;
        s_tag = '{io.alloc_tag0, io.alloc_tag1, io.alloc_tag2, io.alloc_tag3};
        fc0 = fq.size();
        rdy = !rec && fc0 >= 4 && !fl;
        check("dec_ready", s_rdy, rdy);
        check("alloc_fire", s_fire, v && rdy);
        check("restore_en", s_re, rec);
        check("free_count", s_fc, fc0);
        check("err", s_err, merr);
        if (fc0 >= 4) begin
            idx = 0;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("alloc_tag%0d", k), s_tag[k], wen[k] ? fq[idx] : 0);
                idx += int'(wen[k]);
            end
        end
        if (v && rdy)
            for (int k = 0; k < 4; k++)
                if (wen[k]) spq.push_back(fq.pop_front());
        n = $countones(c_en);
        ret_q.delete();
        if (n != 0) begin
            if (fc0 + n > 64) merr = 1'b1;
            else begin
                for (int k = 0; k < 4; k++)
                    if (c_en[k]) fq.push_back(int'(c_tag[k]));
                if (n > spq.size()) merr = 1'b1;
                repeat (n) if (spq.size() != 0) ret_q.push_back(spq.pop_front());
            end
        end
        if (fl)
            while (spq.size() != 0) fq.push_front(spq.pop_back());
        rec = fl;
    endtask
    initial begin
        //           v     wen   cen   ct                            fl    rdy   fire  tag                              re    fc     er
        tbl[0] = '{1'b1, 4'hF, 4'h0, 24'h0,                        1'b0, 1'b1, 1'b1, {6'd35, 6'd34, 6'd33, 6'd32}, 1'b0, 7'd32, 1'b0};
        tbl[1] = '{1'b0, 4'hA, 4'h0, 24'h0,                        1'b0, 1'b1, 1'b0, {6'd37, 6'd0, 6'd36, 6'd0},   1'b0, 7'd28, 1'b0};
        tbl[2] = '{1'b1, 4'hA, 4'h0, 24'h0,                        1'b0, 1'b1, 1'b1, {6'd37, 6'd0, 6'd36, 6'd0},   1'b0, 7'd28, 1'b0};
        tbl[3] = '{1'b1, 4'h0, 4'h0, 24'h0,                        1'b0, 1'b1, 1'b1, 24'h0,                        1'b0, 7'd26, 1'b0};
        tbl[4] = '{1'b0, 4'h1, 4'h3, {6'd0, 6'd0, 6'd2, 6'd1},     1'b0, 1'b1, 1'b0, {6'd0, 6'd0, 6'd0, 6'd38},    1'b0, 7'd26, 1'b0};
        tbl[5] = '{1'b0, 4'h0, 4'h0, 24'h0,                        1'b1, 1'b0, 1'b0, 24'h0,                        1'b0, 7'd28, 1'b0};
        tbl[6] = '{1'b1, 4'hF, 4'h0, 24'h0,                        1'b0, 1'b0, 1'b0, {6'd37, 6'd36, 6'd35, 6'd34}, 1'b1, 7'd32, 1'b0};
        tbl[7] = '{1'b1, 4'hF, 4'h0, 24'h0,                        1'b0, 1'b1, 1'b1, {6'd37, 6'd36, 6'd35, 6'd34}, 1'b0, 7'd32, 1'b0};
        tbl[8] = '{1'b0, 4'h0, 4'h0, 24'h0,                        1'b0, 1'b1, 1'b0, 24'h0,                        1'b0, 7'd28, 1'b0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].v, tbl[i].wen, tbl[i].cen, tbl[i].ct, tbl[i].fl);
            check($sformatf("tbl%0d dec_ready", i), s_rdy, tbl[i].rdy);
            check($sformatf("tbl%0d alloc_fire", i), s_fire, tbl[i].fire);
            check($sformatf("tbl%0d restore_en", i), s_re, tbl[i].re);
            check($sformatf("tbl%0d free_count", i), s_fc, tbl[i].fc);
            check($sformatf("tbl%0d err", i), s_err, tbl[i].er);
            for (int k = 0; k < 4; k++)
                check($sformatf("tbl%0d alloc_tag%0d", i, k), s_tag[k], tbl[i].tag[k]);
        end
        // compressed mask straight after reset
        do_reset();
        cyc(1'b1, 4'b1010, 4'h0, '0, 1'b0);
        check("mask1010 tag0", s_tag[0], 0);
        check("mask1010 tag1", s_tag[1], 32);
        check("mask1010 tag2", s_tag[2], 0);
        check("mask1010 tag3", s_tag[3], 33);
        cyc(1'b0, 4'h0, 4'h0, '0, 1'b0);
        check("mask1010 free_count", s_fc, 30);
        // drain to empty, then refill from commit
        do_reset();
        repeat (8) cyc(1'b1, 4'hF, 4'h0, '0, 1'b0);
        cyc(1'b0, 4'h0, 4'hF, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0);
        check("empty free_count", s_fc, 0);
        check("empty dec_ready", s_rdy, 0);
        cyc(1'b1, 4'hF, 4'h0, '0, 1'b0);
        check("refill free_count", s_fc, 4);
        check("refill dec_ready", s_rdy, 1);
        for (int k = 0; k < 4; k++) check($sformatf("refill tag%0d", k), s_tag[k], k + 1);
        // commit and flush in the same cycle
        do_reset();
        repeat (3) cyc(1'b1, 4'hF, 4'h0, '0, 1'b0);
        cyc(1'b0, 4'h0, 4'hF, {6'd8, 6'd7, 6'd6, 6'd5}, 1'b1);
        cyc(1'b1, 4'hF, 4'h0, '0, 1'b0);
        check("flush restore_en", s_re, 1);
        check("flush dec_ready", s_rdy, 0);
        cyc(1'b1, 4'hF, 4'h0, '0, 1'b0);
        check("post-flush restore_en", s_re, 0);
        check("post-flush free_count", s_fc, 32);
        for (int k = 0; k < 4; k++) check($sformatf("post-flush tag%0d", k), s_tag[k], 36 + k);
        // back-to-back flushes stretch RECOVER
        do_reset();
        cyc(1'b1, 4'hF, 4'h0, '0, 1'b1);
        check("dflush c0 ready", s_rdy, 0);
        check("dflush c0 restore", s_re, 0);
        cyc(1'b1, 4'hF, 4'h0, '0, 1'b1);
        check("dflush c1 ready", s_rdy, 0);
        check("dflush c1 restore", s_re, 1);
        cyc(1'b1, 4'hF, 4'h0, '0, 1'b0);
        check("dflush c2 ready", s_rdy, 0);
        check("dflush c2 restore", s_re, 1);
        cyc(1'b1, 4'hF, 4'h0, '0, 1'b0);
        check("dflush c3 ready", s_rdy, 1);
        check("dflush c3 restore", s_re, 0);
        // commit without allocation pushes count to 62, then overflow is dropped
        do_reset();
        cyc(1'b0, 4'h0, 4'hF, {6'd3, 6'd2, 6'd1, 6'd0}, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, '0, 1'b0);
        check("overtake err", s_err, 1);
        check("overtake free_count", s_fc, 36);
        repeat (6) cyc(1'b0, 4'h0, 4'hF, {6'd7, 6'd6, 6'd5, 6'd4}, 1'b0);
        cyc(1'b0, 4'h0, 4'h3, {6'd0, 6'd0, 6'd9, 6'd8}, 1'b0);
        cyc(1'b0, 4'h0, 4'hF, {6'd13, 6'd12, 6'd11, 6'd10}, 1'b0);
        check("pre-overflow free_count", s_fc, 62);
        cyc(1'b0, 4'h0, 4'h0, '0, 1'b0);
        check("overflow free_count", s_fc, 62);
        check("overflow err", s_err, 1);
        // random traffic with legal commits; many wraps of the 2*NPREG pointers
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cen = 4'($urandom);
            while ($countones(cen) > spq.size()) cen = cen & (cen - 4'd1);
            j = 0;
            ct = '0;
            for (int k = 0; k < 4; k++)
                if (cen[k]) begin
                    ct[k] = 6'(live[j]);
                    j++;
                end
            cyc($urandom_range(0, 3) != 0, 4'($urandom), cen, ct, $urandom_range(0, 31) == 0);
            repeat (j) void'(live.pop_front());
            foreach (ret_q[i]) live.push_back(ret_q[i]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
